// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the coordinate-stack arbiter.
// No logic; latency and backpressure are defined by stack_arbiter.
package stack_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int DEF_W     = 4;
    localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/reg4B.sv
// 4-bit load register with synchronous active-high clear; one-cycle latency.
// No backpressure: holds its value whenever ld is low.
module reg4B (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= 4'd0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; combinational, zero latency.
// No backpressure: a requester that loses a tie keeps its request up and wins next time.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_idx
);
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1)
            gnt_idx = ~last_gnt;
        else if (req1)
            gnt_idx = 1'b1;
    end
endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sequencing one push/pop per grant onto the shared coordinate stack.
// Strobe one cycle after grant, done/err one cycle later; losing requester holds req until served.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic                       req1,
    input  logic                       op0,
    input  logic                       op1,
    input  logic [W-1:0]               xIn0,
    input  logic [W-1:0]               yIn0,
    input  logic [W-1:0]               xIn1,
    input  logic [W-1:0]               yIn1,
    output logic                       done0,
    output logic                       done1,
    output logic                       err0,
    output logic                       err1,
    output logic [W-1:0]               xOut,
    output logic [W-1:0]               yOut,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       push,
    output logic                       pop,
    output logic [W-1:0]               xSt,
    output logic [W-1:0]               ySt,
    input  logic [W-1:0]               xTop,
    input  logic [W-1:0]               yTop,
    input  logic                       fail
);
    localparam int CW = $clog2(DEPTH+1);

    state_t         state, state_nxt;
    logic           last_gnt, gnt_q;
    logic [W-1:0]   x_q, y_q;
    logic           gnt_valid, gnt_idx;
    logic           sel_op, latch_en, gnt_upd, res_ld;
    logic           push_nxt, pop_nxt, done_nxt, err_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic           full, empty;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign xSt   = x_q;
    assign ySt   = y_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Full/empty are decided at grant time: count cannot move while IDLE,
    // which lets the stack strobes come straight out of flops.
    always_comb begin
        state_nxt = state;
        sel_op    = OP_PUSH;
        latch_en  = 1'b0;
        gnt_upd   = 1'b0;
        res_ld    = 1'b0;
        push_nxt  = 1'b0;
        pop_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        cnt_nxt   = count;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    latch_en  = 1'b1;
                    sel_op    = gnt_idx ? op1 : op0;
                    push_nxt  = (sel_op == OP_PUSH) && !full;
                    pop_nxt   = (sel_op == OP_POP) && !empty;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                done_nxt  = 1'b1;
                state_nxt = RESP;
                if (push || pop) begin
                    err_nxt = fail;
                    if (!fail) begin
                        cnt_nxt = push ? count + CW'(1) : count - CW'(1);
                        res_ld  = pop;
                    end
                end else begin
                    err_nxt = 1'b1;
                end
            end
            RESP: begin
                gnt_upd   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            push     <= 1'b0;
            pop      <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            count    <= '0;
        end else begin
            push  <= push_nxt;
            pop   <= pop_nxt;
            count <= cnt_nxt;
            done0 <= done_nxt & ~gnt_q;
            done1 <= done_nxt & gnt_q;
            err0  <= err_nxt & ~gnt_q;
            err1  <= err_nxt & gnt_q;
            if (latch_en) begin
                gnt_q <= gnt_idx;
                x_q   <= gnt_idx ? xIn1 : xIn0;
                y_q   <= gnt_idx ? yIn1 : yIn0;
            end
            if (gnt_upd)
                last_gnt <= gnt_q;
        end
    end

    generate
        if (W == 4) begin : g_res_reg4
            reg4B u_xout (.clk(clk), .rst(rst), .ld(res_ld), .d(xTop), .q(xOut));
            reg4B u_yout (.clk(clk), .rst(rst), .ld(res_ld), .d(yTop), .q(yOut));
        end else begin : g_res_ff
            always_ff @(posedge clk) begin
                if (rst) begin
                    xOut <= '0;
                    yOut <= '0;
                end else if (res_ld) begin
                    xOut <= xTop;
                    yOut <= yTop;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter with a behavioural coordinate stack attached.
module tb_stack_arbiter;
    localparam int W     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, req0, req1, op0, op1, fail;
    logic [W-1:0] xIn0, yIn0, xIn1, yIn1, xTop, yTop, xOut, yOut, xSt, ySt;
    logic         done0, done1, err0, err1, push, pop;
    logic [4:0]   count;

    always #5 clk = ~clk;

    stack_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .xIn0(xIn0), .yIn0(yIn0), .xIn1(xIn1), .yIn1(yIn1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .xOut(xOut), .yOut(yOut), .count(count),
        .push(push), .pop(pop), .xSt(xSt), .ySt(ySt),
        .xTop(xTop), .yTop(yTop), .fail(fail)
    );

    // Behavioural stack: reset by the same rst, untouched when fail is forced
    logic [W-1:0] sx [DEPTH];
    logic [W-1:0] sy [DEPTH];
    int           sp = 0;

    always @(posedge clk) begin
        if (rst)
            sp <= 0;
        else if (push && !fail && sp < DEPTH) begin
            sx[sp] <= xSt;
            sy[sp] <= ySt;
            sp     <= sp + 1;
        end else if (pop && !fail && sp > 0)
            sp <= sp - 1;
    end

    always_comb begin
        xTop = '0;
        yTop = '0;
        if (sp > 0) begin
            xTop = sx[sp-1];
            yTop = sy[sp-1];
        end
    end

    typedef struct {
        bit           idx;
        bit           op;
        logic [W-1:0] x, y;
        bit           fl;
        bit           e_err;
        logic [W-1:0] e_x, e_y;
        int           e_cnt;
        bit           e_stb;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input bit idx, input bit op, input int x, input int y,
                                input bit fl, input bit e_err, input int e_x, input int e_y,
                                input int e_cnt, input bit e_stb);
        vec_t v;
        v.idx = idx;  v.op = op;  v.x = W'(x);  v.y = W'(y);  v.fl = fl;
        v.e_err = e_err;  v.e_x = W'(e_x);  v.e_y = W'(e_y);
        v.e_cnt = e_cnt;  v.e_stb = e_stb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One request through the arbiter; the expected record rides the scoreboard
    task automatic run(input vec_t v, input string tag);
        vec_t e;
        bit   got = 0;
        bit   stb = 0;
        int   lat = 0;
        logic err_s = 1'b0;
        sb.push_back(v);
        @(negedge clk);
        fail = v.fl;
        if (v.idx == 1'b0) begin
            req0 = 1'b1; op0 = v.op; xIn0 = v.x; yIn0 = v.y;
        end else begin
            req1 = 1'b1; op1 = v.op; xIn1 = v.x; yIn1 = v.y;
        end
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            chk({tag, "_strobe_excl"}, push & pop, 0);
            if (push || pop) begin
                stb = 1;
                if (push) begin
                    chk({tag, "_xSt"}, xSt, v.x);
                    chk({tag, "_ySt"}, ySt, v.y);
                end
            end
            if (v.idx == 1'b0 ? done0 : done1) begin
                got   = 1;
                lat   = k;
                err_s = (v.idx == 1'b0) ? err0 : err1;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_done timeout: no done within 8 cycles, required one", tag);
        end else begin
            chk({tag, "_latency"}, lat, 2);
            chk({tag, "_err"}, err_s, e.e_err);
            chk({tag, "_xOut"}, xOut, e.e_x);
            chk({tag, "_yOut"}, yOut, e.e_y);
            chk({tag, "_count"}, count, e.e_cnt);
            chk({tag, "_strobe"}, stb, e.e_stb);
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        fail = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_push"}, push, 0);
        chk({tag, "_pop"}, pop, 0);
        chk({tag, "_done"}, {done0, done1}, 0);
        chk({tag, "_err"}, {err0, err1}, 0);
        chk({tag, "_xyOut"}, {xOut, yOut}, 0);
        chk({tag, "_xySt"}, {xSt, ySt}, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin
        int ncyc;
        int dcyc [4];
        int didx [4];

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0; fail = 1'b0;
        xIn0 = '0; yIn0 = '0; xIn1 = '0; yIn1 = '0;

        tbl[0] = mk(0, 0, 3, 5, 0, 0, 0, 0, 1, 1);  // push (3,5)
        tbl[1] = mk(1, 1, 0, 0, 0, 0, 3, 5, 0, 1);  // pop returns (3,5)
        tbl[2] = mk(0, 1, 0, 0, 0, 1, 3, 5, 0, 0);  // pop on empty
        tbl[3] = mk(1, 0, 9, 2, 1, 1, 3, 5, 0, 1);  // push with stack fail
        tbl[4] = mk(1, 0, 7, 1, 0, 0, 3, 5, 1, 1);  // push (7,1)
        tbl[5] = mk(0, 1, 0, 0, 1, 1, 3, 5, 1, 1);  // pop with stack fail
        tbl[6] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 1);  // pop returns (7,1)

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < DEPTH; i++)
            run(mk(i[0], 0, i, 15 - i, 0, 0, 7, 1, i + 1, 1), $sformatf("fill%0d", i));
        run(mk(0, 0, 1, 1, 0, 1, 7, 1, DEPTH, 0), "overfill");
        for (int i = DEPTH - 1; i >= 0; i--)
            run(mk(i[1], 1, 0, 0, 0, 0, i, 15 - i, i, 1), $sformatf("lifo%0d", i));
        run(mk(1, 0, 4, 4, 0, 0, 0, 15, 1, 1), "pre_abort");

        // Reset landing on the ISSUE cycle of a push aborts it with no done
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; xIn0 = 4'd9; yIn0 = 4'd9;
        @(posedge clk); #1;
        chk("abort_issue_push", push, 1);
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b0;
        @(posedge clk); #1;
        chk_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {done0, done1}, 0);
        end

        // Both requesters held high from reset must alternate 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; op0 = 1'b0; xIn0 = 4'd1; yIn0 = 4'd2;
        req1 = 1'b1; op1 = 1'b0; xIn1 = 4'd3; yIn1 = 4'd4;
        ncyc = 0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            chk("tie_done_excl", done0 & done1, 0);
            if ((done0 || done1) && ncyc < 4) begin
                dcyc[ncyc] = c;
                didx[ncyc] = done1 ? 1 : 0;
                ncyc++;
            end
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        chk("tie_num_done", ncyc, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ncyc) begin
                chk($sformatf("tie_cycle%0d", k), dcyc[k], 2 + 3 * k);
                chk($sformatf("tie_idx%0d", k), didx[k], k % 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
